// File: rtl/operand2_unit.sv
`default_nettype none
//============================================================================
// Module   : operand2_unit
// Purpose  : Sequential front end for the ARM data-processing second
//            operand. Latches an instruction word, fetches Rm (and Rs for
//            register-specified shifts) from the register file, drives an
//            external combinational barrel shifter with a legal opcode and
//            5-bit amount, and patches the architecturally special shift
//            cases before returning operand2 and the shifter carry-out.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/instr/carry_flag  - instruction intake
//            rf_rd_en/rf_addr/rf_data            - register-file read port
//            sh_a/sh_opcode/sh_shift/sh_carry_in - shifter drive
//            sh_result/sh_carry_out              - shifter return
//            out_valid/out_ready/op2/shifter_carry - result to ALU stage
// Config   : OP2_SHIFT_REG_EN - when defined, register-specified shifts are
//            supported (extra RD_S read of Rs). When undefined such
//            instructions pass Rm through unshifted with carry = C.
// Revision : 1.0 - initial release
//============================================================================
module operand2_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        carry_flag,
  output logic        rf_rd_en,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] sh_a,
  output logic [2:0]  sh_opcode,
  output logic [4:0]  sh_shift,
  output logic        sh_carry_in,
  input  logic [31:0] sh_result,
  input  logic        sh_carry_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op2,
  output logic        shifter_carry
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_rd_s = 3'd1;
  localparam logic [2:0] c_st_rd_m = 3'd2;
  localparam logic [2:0] c_st_exec = 3'd3;
  localparam logic [2:0] c_st_hold = 3'd4;

  localparam logic [2:0] c_op_lsl = 3'd0;
  localparam logic [2:0] c_op_lsr = 3'd1;
  localparam logic [2:0] c_op_asr = 3'd2;
  localparam logic [2:0] c_op_ror = 3'd3;
  localparam logic [2:0] c_op_rrx = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_imm;        // I bit of the latched instruction
  logic [11:0] r_instr;      // low instruction bits that carry operand2 fields
  logic        r_c;          // CPSR C captured on accept
  logic [31:0] r_op2;
  logic        r_carry;
  logic [31:0] w_op2;
  logic        w_carry;
  logic [4:0]  w_amt5;
  logic [4:0]  w_idx_l;      // 32-s : carry bit for LSL
  logic [4:0]  w_idx_r;      // s-1  : carry bit for LSR/ASR/ROR
  logic        w_unused;

`ifdef OP2_SHIFT_REG_EN
  logic [7:0]  r_amt;        // Rs[7:0] for register-specified shifts
  assign w_amt5 = r_instr[4] ? r_amt[4:0] : r_instr[11:7];
`else
  assign w_amt5 = r_instr[11:7];
`endif

  // Modulo-32 arithmetic gives 32-s directly for s in 1..31.
  assign w_idx_l  = 5'd0 - w_amt5;
  assign w_idx_r  = w_amt5 - 5'd1;
  assign w_unused = ^{instr[31:26], instr[24:12]};

  assign in_ready      = (r_state == c_st_idle);
  assign out_valid     = (r_state == c_st_hold);
  assign op2           = r_op2;
  assign shifter_carry = r_carry;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (in_valid) begin
          if (instr[25]) begin
            w_next = c_st_exec;
`ifdef OP2_SHIFT_REG_EN
          end else if (instr[4]) begin
            w_next = c_st_rd_s;
`endif
          end else begin
            w_next = c_st_rd_m;
          end
        end
      end
      c_st_rd_s: w_next = c_st_rd_m;
      c_st_rd_m: w_next = c_st_exec;
      c_st_exec: w_next = c_st_hold;
      c_st_hold: if (out_ready) w_next = c_st_idle;
      default:   w_next = c_st_idle;
    endcase
  end

  always_comb begin
    rf_rd_en = 1'b0;
    rf_addr  = 4'd0;
    case (r_state)
      c_st_rd_s: begin
        rf_rd_en = 1'b1;
        rf_addr  = r_instr[11:8];
      end
      c_st_rd_m: begin
        rf_rd_en = 1'b1;
        rf_addr  = r_instr[3:0];
      end
      default: ;
    endcase
  end

  // Shifter drive and result correction. Outside EXEC the shifter sees a
  // stable LSL #0 of zero and the result registers simply hold.
  always_comb begin
    sh_a        = 32'd0;
    sh_opcode   = c_op_lsl;
    sh_shift    = 5'd0;
    sh_carry_in = 1'b0;
    w_op2       = r_op2;
    w_carry     = r_carry;
    if (r_state == c_st_exec) begin
      sh_carry_in = r_c;
      if (r_imm) begin
        sh_a = {24'd0, r_instr[7:0]};
        if (r_instr[11:8] == 4'd0) begin
          w_op2   = {24'd0, r_instr[7:0]};
          w_carry = r_c;
        end else begin
          sh_opcode = c_op_ror;
          sh_shift  = {r_instr[11:8], 1'b0};
          w_op2     = sh_result;
          w_carry   = sh_result[31];
        end
      end else begin
        sh_a = rf_data;
        if (r_instr[4]) begin
`ifdef OP2_SHIFT_REG_EN
          if (r_amt == 8'd0) begin
            w_op2   = rf_data;
            w_carry = r_c;
          end else begin
            case (r_instr[6:5])
              2'd0: begin
                if (r_amt < 8'd32) begin
                  sh_opcode = c_op_lsl;
                  sh_shift  = w_amt5;
                  w_op2     = sh_result;
                  w_carry   = rf_data[w_idx_l];
                end else begin
                  w_op2   = 32'd0;
                  w_carry = (r_amt == 8'd32) ? rf_data[0] : 1'b0;
                end
              end
              2'd1: begin
                if (r_amt < 8'd32) begin
                  sh_opcode = c_op_lsr;
                  sh_shift  = w_amt5;
                  w_op2     = sh_result;
                  w_carry   = rf_data[w_idx_r];
                end else begin
                  w_op2   = 32'd0;
                  w_carry = (r_amt == 8'd32) ? rf_data[31] : 1'b0;
                end
              end
              2'd2: begin
                if (r_amt < 8'd32) begin
                  sh_opcode = c_op_asr;
                  sh_shift  = w_amt5;
                  w_op2     = sh_result;
                  w_carry   = rf_data[w_idx_r];
                end else begin
                  w_op2   = {32{rf_data[31]}};
                  w_carry = rf_data[31];
                end
              end
              default: begin
                // Rotation by a nonzero multiple of 32 leaves Rm intact.
                if (w_amt5 == 5'd0) begin
                  w_op2   = rf_data;
                  w_carry = rf_data[31];
                end else begin
                  sh_opcode = c_op_ror;
                  sh_shift  = w_amt5;
                  w_op2     = sh_result;
                  w_carry   = sh_result[31];
                end
              end
            endcase
          end
`else
          w_op2   = rf_data;
          w_carry = r_c;
`endif
        end else begin
          case (r_instr[6:5])
            2'd0: begin
              if (w_amt5 == 5'd0) begin
                w_op2   = rf_data;
                w_carry = r_c;
              end else begin
                sh_opcode = c_op_lsl;
                sh_shift  = w_amt5;
                w_op2     = sh_result;
                w_carry   = rf_data[w_idx_l];
              end
            end
            2'd1: begin
              if (w_amt5 == 5'd0) begin
                w_op2   = 32'd0;
                w_carry = rf_data[31];
              end else begin
                sh_opcode = c_op_lsr;
                sh_shift  = w_amt5;
                w_op2     = sh_result;
                w_carry   = rf_data[w_idx_r];
              end
            end
            2'd2: begin
              if (w_amt5 == 5'd0) begin
                w_op2   = {32{rf_data[31]}};
                w_carry = rf_data[31];
              end else begin
                sh_opcode = c_op_asr;
                sh_shift  = w_amt5;
                w_op2     = sh_result;
                w_carry   = rf_data[w_idx_r];
              end
            end
            default: begin
              if (w_amt5 == 5'd0) begin
                sh_opcode = c_op_rrx;
                w_op2     = sh_result;
                w_carry   = sh_carry_out;
              end else begin
                sh_opcode = c_op_ror;
                sh_shift  = w_amt5;
                w_op2     = sh_result;
                w_carry   = rf_data[w_idx_r];
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_imm   <= 1'b0;
      r_instr <= 12'd0;
      r_c     <= 1'b0;
      r_op2   <= 32'd0;
      r_carry <= 1'b0;
`ifdef OP2_SHIFT_REG_EN
      r_amt   <= 8'd0;
`endif
    end else begin
      r_state <= w_next;
      if ((r_state == c_st_idle) && in_valid) begin
        r_imm   <= instr[25];
        r_instr <= instr[11:0];
        r_c     <= carry_flag;
      end
`ifdef OP2_SHIFT_REG_EN
      // Rs was addressed in RD_S, so its data is on rf_data during RD_M.
      if ((r_state == c_st_rd_m) && r_instr[4]) begin
        r_amt <= rf_data[7:0];
      end
`endif
      if (r_state == c_st_exec) begin
        r_op2   <= w_op2;
        r_carry <= w_carry;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/operand2_unit.md
# operand2_unit

Sequential front end for the ARM data-processing second operand (operand2). Accepts a data-processing instruction word through a valid/ready handshake and fetches Rm and, for register-specified shifts, Rs from the register file. It drives the combinational barrel shifter with a legal opcode and a 5-bit amount, then corrects the architecturally special cases: amount 0, 32 and >32, `LSR/ASR #0`, and `ROR #0`=RRX. It returns the final operand2 and shifter carry-out to the ALU stage.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `instr` in 32: instruction word. Fields used:
  - [25] I
  - [11:8] rot / Rs
  - [11:7] imm shift
  - [6:5] shift type
  - [4] register-shift
  - [7:0] imm8
  - [3:0] Rm
- `carry_flag` in 1: CPSR C, sampled on accept.
- `rf_rd_en` out 1: register-file read strobe.
- `rf_addr` out 4: read address.
- `rf_data` in 32: read data, valid the cycle after `rf_rd_en`.
- `sh_a` out 32: shifter operand.
- `sh_opcode` out 3: shifter opcode. 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX.
- `sh_shift` out 5: shifter amount.
- `sh_carry_in` out 1: shifter carry-in.
- `sh_result` in 32: shifter result (combinational).
- `sh_carry_out` in 1: shifter carry-out; used only for RRX.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `op2` out 32: final operand2.
- `shifter_carry` out 1: final shifter carry-out.

## Operation
- Accept on the `in_valid && in_ready` edge: latch `instr` and `carry_flag`. Shifter inputs are never sourced from live `instr`.
- State machine:
  - IDLE → EXEC if I=1.
  - IDLE → RD_M if I=0, [4]=0.
  - IDLE → RD_S if I=0, [4]=1.
  - RD_S → RD_M.
  - RD_M → EXEC.
  - EXEC → HOLD.
  - HOLD → IDLE on `out_ready`.
- RD_S: `rf_rd_en`=1, `rf_addr`=Rs.
- RD_M: `rf_rd_en`=1, `rf_addr`=Rm. On entry from RD_S, latch amount = `rf_data[7:0]` (8 bits).
- EXEC: `sh_a`=`rf_data` (Rm), or zero-extended imm8 for I=1. Compute `op2`/`shifter_carry` and register them at the end of EXEC.
- `rf_rd_en`=0 in every other state.
- In RD_S/RD_M/HOLD/IDLE, shifter outputs are don't-care but driven stably: `sh_opcode`=0, `sh_shift`=0.
- Immediate (I=1): n = 2·rot, driven as ROR.
  - n=0: bypass (`op2`=imm8, carry=C).
  - Otherwise: `op2`=`sh_result`, carry=`sh_result[31]`.
- Immediate shift, amount s = [11:7]:
  - `LSL #0`: `op2`=Rm, carry=C.
  - `LSL #s`: carry=Rm[32−s].
  - `LSR #0` means 32: `op2`=0, carry=Rm[31].
  - `LSR #s`: carry=Rm[s−1].
  - `ASR #0` means 32: `op2`={32{Rm[31]}}, carry=Rm[31].
  - `ASR #s`: carry=Rm[s−1].
  - `ROR #0` is RRX: `sh_opcode`=4, `op2`=`sh_result`, carry=`sh_carry_out`.
  - `ROR #s`: carry=Rm[s−1].
- Register shift, amount r = Rs[7:0]:
  - r=0, any type: `op2`=Rm, carry=C.
  - LSL r=32: `op2`=0, carry=Rm[0].
  - LSL r>32: `op2`=0, carry=0.
  - LSR r=32: `op2`=0, carry=Rm[31].
  - LSR r>32: `op2`=0, carry=0.
  - ASR r≥32: `op2`={32{Rm[31]}}, carry=Rm[31].
  - ROR, r[4:0]=0, r≠0: `op2`=Rm, carry=Rm[31].
  - ROR otherwise: rotate by r[4:0], carry=`sh_result[31]`.
  - 1≤r≤31 (LSL/LSR/ASR): shifter result; carry as in the immediate rules.
- The unit never drives ROR or ASR with `sh_shift`=0. Those cases use the bypass path.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `rf_rd_en`=0, `rf_addr`=0, `op2`=0, `shifter_carry`=0, `sh_*`=0.
- Latency from accept edge to `out_valid` high:
  - immediate: 2 cycles
  - immediate shift: 3 cycles
  - register shift: 4 cycles
- HOLD: `op2`/`shifter_carry` held stable while `out_valid && !out_ready`. The transfer occurs on the edge with `out_ready`=1. `in_ready` rises the next cycle.
- No overlap: throughput is one instruction per (latency + 1) cycles minimum.
- `in_valid` while not in IDLE is ignored; the instruction is not latched.
- Reset asserted mid-operation (any state): immediate return to IDLE, `out_valid`=0, pending instruction discarded.

## Configuration
- `OP2_SHIFT_REG_EN` defined: register-specified shifts supported as above; RD_S present.
- Not defined: RD_S removed. I=0 with [4]=1 takes the RD_M path; `op2`=Rm unshifted, carry=C, latency 3.

## Test plan
- Immediate: imm8=0xFF, rot=4, C=0 → `op2`=0xFF000000, carry=1, `out_valid` 2 cycles after accept.
- `LSR #0`: Rm=0x80000000 → `op2`=0, carry=1. `ASR #0`, same Rm → `op2`=0xFFFFFFFF, carry=1. Both: `rf_rd_en` pulses once with `rf_addr`=Rm.
- `ROR #0` (RRX): Rm=0x00000003, C=1 → `op2`=0x80000001, carry=1. `sh_opcode`=4 seen in EXEC.
- Register LSL, Rs=0x120 (r=0x20=32), Rm=0x00000001 → `op2`=0, carry=1. Rs=33 → carry=0. Rs=0x100 (r=0) → `op2`=Rm, carry=C. Latency 4. Reads Rs then Rm.
- Register ROR, Rs=32, Rm=0x80000001 → `op2`=0x80000001, carry=1, `sh_opcode`≠3 with shift 0 at all times.
- Backpressure and reset:
  - `out_ready`=0 for 3 cycles → `op2` stable, `in_ready`=0, second `in_valid` ignored.
  - Reset pulsed in RD_M → `out_valid` stays 0, `in_ready`=1 after reset deassert, next instruction processed correctly.
